// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchronizes rx_i, frames start/data/parity/stop
// LSB first, and hands each word out through a one-entry valid/ready buffer.
module uart_rx #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV   = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             ODD_BIT   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [OS_W-1:0]      os_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bad_reg;
    state_t               state_reg;
    logic [DATA_BITS-1:0] m_data_reg;
    logic                 m_valid_reg;
    logic                 frame_err_reg;
    logic                 parity_err_reg;
    logic                 overrun_reg;

    logic tick;
    logic handshake;

    assign tick      = (div_cnt_reg == DIV_LAST);
    assign handshake = m_valid_reg && m_ready;

    assign m_data     = m_data_reg;
    assign m_valid    = m_valid_reg;
    assign frame_err  = frame_err_reg;
    assign parity_err = parity_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx_i;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            div_cnt_reg    <= '0;
            os_cnt_reg     <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_bad_reg <= 1'b0;
            m_data_reg     <= '0;
            m_valid_reg    <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            div_cnt_reg    <= tick ? '0 : div_cnt_reg + 1'b1;
            if (handshake) begin
                m_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    // Realign the tick phase to the falling edge of the start bit.
                    if (!rx_s_reg) begin
                        state_reg      <= START;
                        div_cnt_reg    <= '0;
                        os_cnt_reg     <= '0;
                        bit_cnt_reg    <= '0;
                        parity_bad_reg <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (os_cnt_reg == HALF_LAST) begin
                            os_cnt_reg <= '0;
                            state_reg  <= rx_s_reg ? IDLE : DATA;
                        end else begin
                            os_cnt_reg <= os_cnt_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (os_cnt_reg == FULL_LAST) begin
                            os_cnt_reg <= '0;
                            shift_reg  <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                            if (bit_cnt_reg == BITS_LAST) begin
                                bit_cnt_reg <= '0;
                                state_reg   <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end else begin
                            os_cnt_reg <= os_cnt_reg + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (os_cnt_reg == FULL_LAST) begin
                            os_cnt_reg     <= '0;
                            parity_bad_reg <= (rx_s_reg != ((^shift_reg) ^ ODD_BIT));
                            state_reg      <= STOP;
                        end else begin
                            os_cnt_reg <= os_cnt_reg + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (os_cnt_reg == FULL_LAST) begin
                            os_cnt_reg <= '0;
                            if (!rx_s_reg) begin
                                frame_err_reg <= 1'b1;
                                state_reg     <= WAIT_HIGH;
                            end else if (parity_bad_reg) begin
                                parity_err_reg <= 1'b1;
                                state_reg      <= IDLE;
                            end else begin
                                // A word landing in the handshake cycle replaces the one leaving.
                                if (m_valid_reg && !m_ready) begin
                                    overrun_reg <= 1'b1;
                                end else begin
                                    m_data_reg  <= shift_reg;
                                    m_valid_reg <= 1'b1;
                                end
                                state_reg <= IDLE;
                            end
                        end else begin
                            os_cnt_reg <= os_cnt_reg + 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: an 8N1 instance and an 8E1 instance,
// each fed its own serial line, with expected events queued per frame.
module tb_uart_rx;

    localparam int CLK_HZ  = 1600000;
    localparam int BAUD_R  = 10000;
    localparam int OS      = 16;
    localparam int BIT_CLK = 160;

    typedef enum int {EV_WORD, EV_PERR, EV_FERR, EV_OVR} ev_kind_t;
    typedef struct {
        int         dut;
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx [2];
    logic       m_ready [2];
    logic [7:0] m_data [2];
    logic       m_valid [2];
    logic       frame_err [2];
    logic       parity_err [2];
    logic       overrun [2];
    logic       busy [2];

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  hold_mode [2];
    bit  held [2];

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS),
              .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx_i(rx[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]),
        .overrun(overrun[0]), .busy(busy[0])
    );

    uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS),
              .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_i(rx[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]),
        .overrun(overrun[1]), .busy(busy[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Match an observed event against the oldest expectation of the same class for that DUT.
    task automatic observe(input int d, input ev_kind_t k, input logic [7:0] data);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].dut == d && ((exp_q[i].kind == EV_WORD) == (k == EV_WORD))) begin
                idx = i;
                break;
            end
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event dut%0d: got kind %s data 0x%0h, expected nothing",
                     d, k.name(), data);
        end else begin
            check($sformatf("event_kind_dut%0d", d), k, exp_q[idx].kind);
            if (k == EV_WORD) begin
                check($sformatf("word_data_dut%0d", d), data, exp_q[idx].data);
            end
            $display("dut%0d event %s data 0x%02h", d, k.name(), data);
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (m_valid[d] && m_ready[d]) observe(d, EV_WORD, m_data[d]);
                if (parity_err[d]) observe(d, EV_PERR, 8'h00);
                if (frame_err[d])  observe(d, EV_FERR, 8'h00);
                if (overrun[d])    observe(d, EV_OVR, 8'h00);
            end
        end
    end

    // Reference rule: a low stop bit wins, then parity, otherwise the word is good.
    function automatic ev_kind_t frame_outcome(input bit par_en, input logic [7:0] data,
                                               input bit par_bit, input bit stop_bit);
        if (!stop_bit) return EV_FERR;
        if (par_en && (par_bit != ($countones(data) % 2 == 1))) return EV_PERR;
        return EV_WORD;
    endfunction

    task automatic push_exp(input int d, input ev_kind_t k, input logic [7:0] data);
        ev_t e;
        e.dut  = d;
        e.kind = k;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int d, input logic b);
        rx[d] = b;
        idle(BIT_CLK);
    endtask

    task automatic send_frame(input int d, input logic [7:0] data, input bit flip_par,
                              input bit stop_bit, input int low_bits);
        bit       par;
        ev_kind_t k;
        par = ($countones(data) % 2 == 1) ^ flip_par;
        k   = frame_outcome(d == 1, data, par, stop_bit);
        if (k == EV_WORD && hold_mode[d]) begin
            if (held[d]) push_exp(d, EV_OVR, 8'h00);
            else begin
                push_exp(d, EV_WORD, data);
                held[d] = 1'b1;
            end
        end else begin
            push_exp(d, k, data);
        end
        drive_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
        if (d == 1) drive_bit(d, par);
        drive_bit(d, stop_bit);
        if (!stop_bit) idle(low_bits * BIT_CLK);
        rx[d] = 1'b1;
    endtask

    task automatic check_quiet(input int d, input string tag);
        check($sformatf("%s_m_valid", tag), m_valid[d], 1'b0);
        check($sformatf("%s_m_data", tag), m_data[d], 8'h00);
        check($sformatf("%s_busy", tag), busy[d], 1'b0);
        check($sformatf("%s_frame_err", tag), frame_err[d], 1'b0);
        check($sformatf("%s_parity_err", tag), parity_err[d], 1'b0);
        check($sformatf("%s_overrun", tag), overrun[d], 1'b0);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int         cnt;
        logic [7:0] abort_data;
        rx[0] = 1'b1; rx[1] = 1'b1;
        m_ready[0] = 1'b1; m_ready[1] = 1'b1;
        hold_mode[0] = 1'b0; hold_mode[1] = 1'b0;
        held[0] = 1'b0; held[1] = 1'b0;
        rst_n = 1'b0;
        idle(3);
        check_quiet(0, "reset_dut0");
        check_quiet(1, "reset_dut1");
        rst_n = 1'b1;
        idle(20);

        // 0xA5 8N1 with latency from the start edge to m_valid
        cnt = 0;
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b1, 0);
            begin
                while (!m_valid[0] && cnt < 3000) begin
                    @(negedge clk);
                    cnt++;
                end
                checks++;
                if (cnt < 1518 || cnt > 1530) begin
                    errors++;
                    $display("FAIL latency_a5: got %0d cycles, expected about 1524", cnt);
                end
            end
        join
        idle(80);

        // Parity instance: good parity, then a flipped parity bit
        fork
            send_frame(1, 8'h03, 1'b0, 1'b1, 0);
            begin
                idle(400);
                check("busy_mid_frame", busy[1], 1'b1);
            end
        join
        idle(80);
        send_frame(1, 8'h03, 1'b1, 1'b1, 0);
        idle(80);

        // Break: stop bit low, line held low 20 bit times
        send_frame(0, 8'h3C, 1'b0, 1'b0, 20);
        idle(80);
        check("busy_after_break", busy[0], 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 0);
        idle(80);

        // Overrun with the consumer stalled
        m_ready[0] = 1'b0;
        hold_mode[0] = 1'b1;
        send_frame(0, 8'h11, 1'b0, 1'b1, 0);
        idle(40);
        send_frame(0, 8'h22, 1'b0, 1'b1, 0);
        idle(40);
        check("held_m_valid", m_valid[0], 1'b1);
        check("held_m_data", m_data[0], 8'h11);
        m_ready[0] = 1'b1;
        hold_mode[0] = 1'b0;
        held[0] = 1'b0;
        idle(2);
        check("m_valid_after_consume", m_valid[0], 1'b0);

        // Short glitch must not start a frame
        rx[0] = 1'b0;
        idle(40);
        rx[0] = 1'b1;
        idle(200);
        check("busy_after_glitch", busy[0], 1'b0);
        send_frame(0, 8'hC3, 1'b0, 1'b1, 0);
        idle(80);

        // Randomized frames on both instances
        for (int i = 0; i < 12; i++) begin
            int         d;
            logic [7:0] data;
            bit         flip;
            bit         stop;
            d    = i % 2;
            data = 8'($urandom_range(0, 255));
            flip = (d == 1) && ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, data, flip, stop, 0);
            idle($urandom_range(5, 60));
        end
        idle(80);

        // Reset in the middle of data bit 4
        abort_data = 8'h96;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, abort_data[i]);
        rx[0] = abort_data[4];
        idle(80);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        @(negedge clk);
        check_quiet(0, "midreset_dut0");
        idle(10);
        rst_n = 1'b1;
        idle(320);
        send_frame(0, 8'h7E, 1'b0, 1'b1, 0);
        idle(400);

        check("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's UART transmit path.
- Oversamples the asynchronous rx line and frames start/data/optional parity/stop bits, LSB first.
- Presents each received word through a one-entry valid/ready output buffer.
- Reports framing, parity and overrun errors as single-cycle pulses.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit (even, >=4)
DATA_BITS, 8, data bits per frame (5..9)
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx_i  input  1  serial line; asynchronous to clk; idles high
m_data  output  DATA_BITS  received word, bit 0 = first bit on the line
m_valid  output  1  m_data holds an unconsumed word
m_ready  input  1  consumer accepts m_data when m_valid && m_ready
frame_err  output  1  1-cycle pulse: stop bit sampled low
parity_err  output  1  1-cycle pulse: parity mismatch
overrun  output  1  1-cycle pulse: completed word dropped because the buffer was full
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync release): synchronizer flops = 1, FSM = IDLE, all counters = 0, m_data = 0, m_valid = 0, all error pulses = 0, busy = 0.
- rx_i passes through a 2-flop synchronizer (rx_s). All logic uses rx_s only.
- Tick divider: DIV = CLK_FREQ_HZ / (BAUD*OVERSAMPLE), integer floor.
  - Free-running counter 0..DIV-1; it is restarted at the start-bit edge. tick = 1 for one clk at count DIV-1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. All sampling happens on tick cycles.
  - IDLE: on rx_s = 0, go to START, clear the sample counter, restart the divider.
  - START: after OVERSAMPLE/2 ticks (mid-bit), sample rx_s.
    - rx_s = 1: glitch; return to IDLE with no flags.
    - rx_s = 0: go to DATA.
  - DATA: every OVERSAMPLE ticks, shift rx_s into the shift register, LSB first.
    - After DATA_BITS samples, go to PARITY if PARITY_EN = 1, else STOP.
  - PARITY: after OVERSAMPLE ticks, sample rx_s.
    - Expected value = XOR of the data bits, inverted when PARITY_ODD = 1.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - rx_s = 1 and parity OK: word completes; go to IDLE.
    - rx_s = 0: frame_err pulses, word discarded; go to WAIT_HIGH.
    - rx_s = 1 with parity mismatch: parity_err pulses, word discarded; go to IDLE.
    - If both errors occur in one frame, only frame_err is raised.
  - WAIT_HIGH: stay until rx_s = 1, then go to IDLE. A break condition produces exactly one frame_err.
- Output buffer:
  - Word completion loads m_data and sets m_valid on the clock after the stop-bit sample cycle.
  - m_valid stays high and m_data stays stable until the m_valid && m_ready cycle, then m_valid = 0 next cycle.
  - Completion while m_valid = 1 and m_ready = 0: new word dropped, old word kept, overrun pulses.
  - Completion in the same cycle as a handshake: new word loaded, m_valid stays 1, no overrun.
- m_ready has no effect on reception; the receiver never stalls.
- Mid-frame reset: frame abandoned, state returns to the reset state; no flag is raised after release.
- A frame whose start bit goes low while rx_s is already low in IDLE (line held low out of reset) is received as a normal start.

Test Plan:
Sim params CLK_FREQ_HZ=1600000, BAUD=10000, OVERSAMPLE=16, so DIV=10 and a bit lasts 160 clk.
- Drive 0xA5 (8N1), m_ready=1 -> m_valid pulses 1 cycle with m_data=0xA5, about 1520 clk after the start edge; no error flags.
- PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 0 -> m_data=0x03; repeat with parity bit 1 -> parity_err pulses once, m_valid stays 0.
- Stop bit driven low, then line low for 20 bit times, then high -> exactly one frame_err, no m_valid; a following 0x5A is received correctly.
- m_ready=0, send 0x11 then 0x22 -> m_valid=1 with m_data=0x11, overrun pulses at the end of 0x22; m_ready=1 consumes 0x11 and m_valid drops.
- 40-clk low glitch on rx_i -> no m_valid, no flags, busy returns to 0; next frame 0xC3 is received correctly.
- Assert rst_n=0 during data bit 4 of a frame, release, send 0x7E -> only 0x7E delivered; outputs are 0 during reset.
